// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arch_defs_pkg
// Brief    : Shared architecture constants plus program loader state and header.
//            LOADER_CHECKSUM_EN adds the CSUM state to loader_state_t.
// Revision : 1.0 - initial release
// ============================================================================
package arch_defs_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [DATA_WIDTH-1:0] LOADER_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : Parses framed load packets from a byte stream and writes them into
//            main RAM while holding the CPU. Macro LOADER_CHECKSUM_EN adds a
//            trailing checksum byte and its verification.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
    import arch_defs_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES = 1_000_000,
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE    = LOADER_HEADER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int                      c_TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TIMER_W-1:0]    c_TIMER_END = c_TIMER_W'(TIMEOUT_CYCLES - 1);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t           c_TAIL_STATE = ST_CSUM;
`else
    localparam loader_state_t           c_TAIL_STATE = ST_DONE;
`endif

    loader_state_t         r_state, w_state_next;
    logic [7:0]            r_remaining, w_remaining_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [c_TIMER_W-1:0]  r_timer, w_timer_next;
    logic                  w_ram_we_next;
    logic [ADDR_WIDTH-1:0] w_ram_addr_next;
    logic [DATA_WIDTH-1:0] w_ram_data_next;
    logic                  w_load_error_next;
    logic                  w_in_packet;
    logic                  w_expired;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum, w_csum_next;
`endif

`ifdef LOADER_CHECKSUM_EN
    assign w_in_packet = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
`else
    assign w_in_packet = (r_state == ST_LEN) || (r_state == ST_DATA);
`endif
    // A byte arriving on the expiry cycle keeps the packet alive
    assign w_expired = w_in_packet && !rx_valid && (r_timer == c_TIMER_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_remaining_next  = r_remaining;
        w_addr_next       = r_addr;
        w_timer_next      = '0;
        w_ram_we_next     = 1'b0;
        w_ram_addr_next   = ram_addr;
        w_ram_data_next   = ram_data;
        w_load_error_next = load_error;
`ifdef LOADER_CHECKSUM_EN
        w_csum_next       = r_csum;
`endif
        if (w_in_packet && !rx_valid) begin
            w_timer_next = r_timer + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == HEADER_BYTE)) begin
                    w_state_next      = ST_LEN;
                    w_load_error_next = 1'b0;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    w_remaining_next = rx_data[7:0];
                    w_addr_next      = '0;
`ifdef LOADER_CHECKSUM_EN
                    w_csum_next      = '0;
`endif
                    w_state_next     = (rx_data[7:0] == 8'd0) ? c_TAIL_STATE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_ram_we_next    = 1'b1;
                    w_ram_addr_next  = r_addr;
                    w_ram_data_next  = rx_data;
                    w_addr_next      = r_addr + 1'b1;
                    w_remaining_next = r_remaining - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                    w_csum_next      = r_csum + rx_data;
`endif
                    if (r_remaining == 8'd1) begin
                        w_state_next = c_TAIL_STATE;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == r_csum) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next      = ST_IDLE;
                        w_load_error_next = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase

        if (w_expired) begin
            w_state_next      = ST_IDLE;
            w_load_error_next = 1'b1;
        end
    end

    // Outputs are registered from the next-state view so they line up with r_state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
            r_addr      <= '0;
            r_timer     <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data    <= '0;
            cpu_hold    <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
        end else begin
            r_remaining <= w_remaining_next;
            r_addr      <= w_addr_next;
            r_timer     <= w_timer_next;
            ram_we      <= w_ram_we_next;
            ram_addr    <= w_ram_addr_next;
            ram_data    <= w_ram_data_next;
            cpu_hold    <= (w_state_next != ST_IDLE);
            busy        <= (w_state_next != ST_IDLE);
            load_done   <= (w_state_next == ST_DONE);
            load_error  <= w_load_error_next;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else begin
            r_csum <= w_csum_next;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Self-checking bench for program_loader; follows LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;
    import arch_defs_pkg::*;

    localparam int TO = 64;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  cpu_hold;
    logic                  busy;
    logic                  load_done;
    logic                  load_error;

    int checks = 0;
    int errors = 0;
    logic [7:0] pkt[$];

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] stp;
        logic [7:0] xr;
        bit         exp_done;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    program_loader #(.TIMEOUT_CYCLES(TO), .HEADER_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_error(load_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of input at a negedge; returns at the next negedge.
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic build(input int n, input logic [7:0] base, input logic [7:0] stp, input logic [7:0] xr);
        logic [7:0] s;
        logic [7:0] b;
        pkt = {};
        pkt.push_back(LOADER_HEADER);
        pkt.push_back(8'(n));
        s = 8'h00;
        b = base;
        for (int i = 0; i < n; i++) begin
            pkt.push_back(b);
            s = s + b;
            b = b + stp;
        end
        if (CSUM_EN) pkt.push_back(s ^ xr);
    endtask

    // Reference: load succeeds unless the trailing byte differs from the data sum mod 256.
    function automatic bit model_good();
        int         n;
        logic [7:0] s;
        n = int'(pkt[1]);
        s = 8'h00;
        if (!CSUM_EN) return 1'b1;
        for (int i = 0; i < n; i++) s = s + pkt[2 + i];
        return pkt[2 + n] == s;
    endfunction

    task automatic run_packet(input string tag, input bit exp_good, input int max_gap);
        int n;
        int last;
        int g;
        bit is_data;
        n    = int'(pkt[1]);
        last = 1 + n + (CSUM_EN ? 1 : 0);
        for (int i = 0; i <= last; i++) begin
            if (i > 0 && max_gap > 0) begin
                g = $urandom_range(max_gap, 0);
                repeat (g) begin
                    step(1'b0, 8'h00);
                    check({tag, "_gap_we"}, 32'(ram_we), 32'd0);
                end
            end
            step(1'b1, pkt[i]);
            is_data = (i >= 2) && (i < 2 + n);
            check({tag, "_we"}, 32'(ram_we), 32'(is_data));
            if (is_data) begin
                check({tag, "_addr"}, 32'(ram_addr), 32'((i - 2) % RAM_DEPTH));
                check({tag, "_data"}, 32'(ram_data), 32'(pkt[i]));
            end
            if (i == last) begin
                check({tag, "_done"}, 32'(load_done), 32'(exp_good));
                check({tag, "_err"}, 32'(load_error), 32'(!exp_good));
                check({tag, "_hold_end"}, 32'(cpu_hold), 32'(exp_good));
            end else begin
                check({tag, "_done_early"}, 32'(load_done), 32'd0);
                check({tag, "_err_mid"}, 32'(load_error), 32'd0);
                check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
            end
        end
        step(1'b0, 8'h00);
        check({tag, "_done_1cyc"}, 32'(load_done), 32'd0);
        check({tag, "_hold_drop"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_err_sticky"}, 32'(load_error), 32'(!exp_good));
    endtask

    initial begin
        bit         corrupt;
        int         n;
        logic [7:0] s;
        logic [7:0] b;

        vecs[0] = '{3,  8'h11, 8'h11, 8'h00, 1'b1};
        vecs[1] = '{2,  8'h10, 8'h10, 8'h01, !CSUM_EN};
        vecs[2] = '{17, 8'h00, 8'h01, 8'h00, 1'b1};
        vecs[3] = '{0,  8'h00, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{1,  8'hFF, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{20, 8'hF0, 8'h07, 8'h80, !CSUM_EN};
        vecs[6] = '{5,  8'h80, 8'h80, 8'h00, 1'b1};

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_error), 32'd0);
        reset = 1'b0;

        // Reset asserted between edges in the middle of a packet
        step(1'b1, 8'hA5);
        step(1'b1, 8'h03);
        step(1'b1, 8'h11);
        check("mid_we", 32'(ram_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(ram_we), 32'd0);
        check("mid_rst_addr", 32'(ram_addr), 32'd0);
        check("mid_rst_data", 32'(ram_data), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h3C);
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_hold", 32'(cpu_hold), 32'd0);
        check("ign_we", 32'(ram_we), 32'd0);
        step(1'b0, 8'h00);
        check("ign_busy2", 32'(busy), 32'd0);

        for (int v = 0; v < 7; v++) begin
            build(vecs[v].n, vecs[v].base, vecs[v].stp, vecs[v].xr);
            run_packet($sformatf("vec%0d", v), vecs[v].exp_done, 0);
        end

        // Silence after one data byte of a four-byte packet
        build(4, 8'hAA, 8'h00, 8'h00);
        step(1'b1, pkt[0]);
        step(1'b1, pkt[1]);
        step(1'b1, pkt[2]);
        check("to_we", 32'(ram_we), 32'd1);
        check("to_addr", 32'(ram_addr), 32'd0);
        for (int i = 0; i < TO - 3; i++) begin
            step(1'b0, 8'h00);
            check("to_idle_we", 32'(ram_we), 32'd0);
        end
        check("to_busy_before", 32'(busy), 32'd1);
        check("to_err_before", 32'(load_error), 32'd0);
        repeat (6) begin
            step(1'b0, 8'h00);
            check("to_idle_we", 32'(ram_we), 32'd0);
        end
        check("to_err", 32'(load_error), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_hold", 32'(cpu_hold), 32'd0);
        check("to_done", 32'(load_done), 32'd0);

        // Byte arriving just as the idle limit is reached still counts
        step(1'b1, 8'hA5);
        check("bw_err_clr", 32'(load_error), 32'd0);
        step(1'b1, 8'h01);
        repeat (TO - 1) step(1'b0, 8'h00);
        step(1'b1, 8'h5A);
        check("bw_we", 32'(ram_we), 32'd1);
        check("bw_data", 32'(ram_data), 32'h5A);
        check("bw_err", 32'(load_error), 32'd0);
        if (CSUM_EN) begin
            repeat (TO - 1) step(1'b0, 8'h00);
            step(1'b1, 8'h5A);
        end
        check("bw_done", 32'(load_done), 32'd1);
        step(1'b0, 8'h00);
        check("bw_idle", 32'(busy), 32'd0);

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(20, 0);
            corrupt = ($urandom_range(3, 0) == 0);
            pkt = {};
            pkt.push_back(LOADER_HEADER);
            pkt.push_back(8'(n));
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                pkt.push_back(b);
                s = s + b;
            end
            if (CSUM_EN) pkt.push_back(corrupt ? (s ^ 8'($urandom_range(255, 1))) : s);
            run_packet($sformatf("rnd%0d", r), model_good(), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Serial program loader feeding the main RAM. Takes bytes from an upstream byte receiver (e.g. UART RX), parses a framed load packet, and drives the RAM write port with sequential address/data/write-enable. Holds the CPU while a load is in progress. Lets a new program be loaded at runtime instead of only from the synthesis-time hex image.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clocks between bytes inside a packet before the load aborts.
- `HEADER_BYTE`, default 8'hA5: start-of-packet marker.

- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data` in DATA_WIDTH: received byte.
- `ram_we` out 1: RAM write enable (one-cycle pulse per data byte).
- `ram_addr` out ADDR_WIDTH: RAM address.
- `ram_data` out DATA_WIDTH: RAM write data.
- `cpu_hold` out 1: high while a packet is being received; the CPU must not fetch.
- `busy` out 1: FSM not in IDLE.
- `load_done` out 1: one-cycle pulse on successful completion.
- `load_error` out 1: sticky error level; cleared when the next header is accepted.

## Operation
- Packet format: `HEADER_BYTE`, `LEN` (8-bit count N), N data bytes, then `CSUM` (only with checksum enabled).
- FSM states: IDLE, LEN, DATA, CSUM, DONE.
- **IDLE:**
  - `rx_valid` with `rx_data==HEADER_BYTE` goes to LEN and clears `load_error`.
  - Any other byte is ignored.
- **LEN:**
  - On a byte, latch N, clear the address counter, and clear the checksum accumulator.
  - If N==0, go to CSUM when enabled, else DONE.
  - Otherwise go to DATA.
- **DATA:** each byte produces `ram_we`=1, `ram_addr`=counter, `ram_data`=byte. Then the counter increments and the remaining count decrements. After the Nth byte, go to CSUM or DONE.
- **CSUM:** on a byte, compare it with the accumulator. On a match go to DONE. On a mismatch set `load_error`, go to IDLE, and do not pulse `load_done`.
- **DONE:** pulse `load_done` for one cycle, then go to IDLE.
- **Checksum:** 8-bit sum modulo 256 of the data bytes only; the header and LEN are excluded.
- **Address wrap:** the counter is ADDR_WIDTH bits and wraps modulo RAM_DEPTH. If N > RAM_DEPTH, later bytes overwrite from address 0.
- **Timeout:**
  - A counter runs whenever in LEN, DATA or CSUM, and resets on every `rx_valid`.
  - On reaching `TIMEOUT_CYCLES`, set `load_error` and return to IDLE. RAM writes already made are kept.
  - If `rx_valid` arrives in the same cycle as expiry, the byte wins and the timeout is ignored.
- `cpu_hold` = 1 in LEN, DATA, CSUM and DONE.
- **Reset mid-packet:** everything clears immediately and the partially written RAM is left as is.

## Timing
- All outputs are registered.
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `cpu_hold`=0, `busy`=0, `load_done`=0, `load_error`=0; state IDLE.
- Write latency is 1 clock. `rx_valid` at edge k produces `ram_we`/`ram_addr`/`ram_data` valid during cycle k+1. The RAM captures them at edge k+2.
- `ram_addr` and `ram_data` hold their last values when `ram_we`=0.
- `cpu_hold` rises the cycle after the header byte is accepted. It falls the cycle after `load_done` is high, or the cycle after an error.
- `load_done` rises the cycle after the final byte (CSUM, or the last data byte when checksum is compiled out), then stays high for exactly one cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted, so there is no stall path.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- **Defined:** the CSUM state and accumulator exist, the packet carries a trailing checksum byte, and a mismatch raises `load_error`.
- **Undefined:** no CSUM state and no accumulator. The packet ends after the data bytes, and the only error source is timeout.

## Structure
- Shared package (`arch_defs_pkg`) holds ADDR_WIDTH, DATA_WIDTH and RAM_DEPTH, which are already there. Add the loader state enum typedef `loader_state_t` and the `LOADER_HEADER` constant there.
- Timeout counter width: $clog2(`TIMEOUT_CYCLES`+1), local to the module.
- No sub-module is needed: the FSM, counters and accumulator sit in one module. The byte receiver is instantiated beside this block, not inside it.

## Test plan
- **Reset:** assert `reset` mid-run → all outputs 0 immediately and FSM in IDLE. After release, a non-header byte 8'h3C produces no response.
- **Good load:** A5 03 11 22 33 66 → writes 11@0, 22@1, 33@2, each `ram_we` one cycle after its byte. `load_done` pulses once, `load_error`=0, and `cpu_hold` drops.
- **Bad checksum:** A5 02 10 20 31 → writes 10@0 and 20@1. `load_error`=1, no `load_done`. The next A5 clears `load_error`.
- **Wrap:** with RAM_DEPTH=16, A5 11 followed by 17 bytes 00..10 → the 17th byte (10) writes address 0. Checksum 88 → `load_done`.
- **Timeout:** A5 04 AA, then silence for `TIMEOUT_CYCLES` → `load_error`=1, FSM in IDLE, `cpu_hold`=0, and only address 0 written.
- **Zero length:** A5 00 00 → no `ram_we`, `load_done` pulses. With `LOADER_CHECKSUM_EN` undefined, A5 00 alone produces the `load_done` pulse.
